// File: rtl/adaptive_phase_controller_if.sv
// Signal bundle between the phase controller and its request/lamp environment.
// Optional emergency pre-emption ports appear only when EMERG_PREEMPT_EN is defined.
interface adaptive_phase_controller_if #(
    parameter int N_APPR = 4
);
    localparam int IDX_W = (N_APPR > 1) ? $clog2(N_APPR) : 1;

    logic [N_APPR-1:0] veh;
    logic [N_APPR-1:0] cong;
    logic [1:0]        state;
    logic [IDX_W-1:0]  active_idx;
    logic [N_APPR-1:0] green;
    logic [N_APPR-1:0] yellow;
    logic              phase_done;
`ifdef EMERG_PREEMPT_EN
    logic              emerg_req;
    logic [IDX_W-1:0]  emerg_idx;

    modport master (
        output veh, cong, emerg_req, emerg_idx,
        input  state, active_idx, green, yellow, phase_done
    );
    modport slave (
        input  veh, cong, emerg_req, emerg_idx,
        output state, active_idx, green, yellow, phase_done
    );
`else
    modport master (
        output veh, cong,
        input  state, active_idx, green, yellow, phase_done
    );
    modport slave (
        input  veh, cong,
        output state, active_idx, green, yellow, phase_done
    );
`endif
endinterface

// File: rtl/adaptive_phase_controller.sv
// Round-robin traffic phase controller with congestion-driven green extension.
// Define EMERG_PREEMPT_EN to add emergency pre-emption (emerg_req / emerg_idx).
module adaptive_phase_controller #(
    parameter int N_APPR   = 4,
    parameter int T_GREEN  = 8,
    parameter int T_EXT    = 6,
    parameter int T_YELLOW = 3,
    parameter int T_ALLRED = 2,
    parameter int CNT_W    = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    adaptive_phase_controller_if.slave   bus
);
    localparam int IDX_W = (N_APPR > 1) ? $clog2(N_APPR) : 1;

    typedef enum logic [1:0] {
        ALL_RED   = 2'd0,
        GREEN     = 2'd1,
        EXT_GREEN = 2'd2,
        YELLOW    = 2'd3
    } phase_t;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_APPR - 1);
    localparam logic [CNT_W-1:0] LD_GREEN  = CNT_W'(T_GREEN - 1);
    localparam logic [CNT_W-1:0] LD_EXT    = CNT_W'(T_EXT - 1);
    localparam logic [CNT_W-1:0] LD_YELLOW = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] LD_ALLRED = CNT_W'(T_ALLRED - 1);

    phase_t            phase_q, phase_d;
    logic [CNT_W-1:0]  timer_q, timer_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [N_APPR-1:0] green_q, green_d;
    logic [N_APPR-1:0] yellow_q, yellow_d;
    logic              done_q, done_d;

    logic              idx_ok;
    logic              win_found;
    logic [IDX_W-1:0]  win_idx;
    logic              preempt;
    logic              freeze;

    assign idx_ok = (int'(idx_q) < N_APPR);

`ifdef EMERG_PREEMPT_EN
    logic emerg_ok;
    assign emerg_ok = bus.emerg_req && (int'(bus.emerg_idx) < N_APPR);
    assign preempt  = emerg_ok && (bus.emerg_idx != idx_q);
    assign freeze   = emerg_ok && (bus.emerg_idx == idx_q);
`else
    assign preempt  = 1'b0;
    assign freeze   = 1'b0;
`endif

    // Search order is idx_q+1 .. idx_q+N (mod N); congestion beats plain presence.
    always_comb begin
        logic             cong_hit, veh_hit;
        logic [IDX_W-1:0] cong_idx, veh_idx, cand;
        int               j;
        cong_hit = 1'b0;
        veh_hit  = 1'b0;
        cong_idx = '0;
        veh_idx  = '0;
        cand     = '0;
        j        = 0;
        for (int k = 1; k <= N_APPR; k++) begin
            j = int'(idx_q) + k;
            if (j >= N_APPR) j = j - N_APPR;
            cand = IDX_W'(j);
            if (!cong_hit && bus.cong[cand]) begin
                cong_hit = 1'b1;
                cong_idx = cand;
            end
            if (!veh_hit && bus.veh[cand]) begin
                veh_hit = 1'b1;
                veh_idx = cand;
            end
        end
        win_found = cong_hit || veh_hit;
        win_idx   = cong_hit ? cong_idx : veh_idx;
`ifdef EMERG_PREEMPT_EN
        if (emerg_ok) begin
            win_found = 1'b1;
            win_idx   = bus.emerg_idx;
        end
`endif
    end

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        phase_d = phase_q;
        timer_d = timer_q;
        idx_d   = idx_q;
        if (!idx_ok) begin
            phase_d = ALL_RED;
            timer_d = LD_ALLRED;
            idx_d   = LAST_IDX;
        end else begin
            unique case (phase_q)
                ALL_RED: begin
                    if (timer_q != '0) begin
                        timer_d = timer_q - CNT_W'(1);
                    end else if (win_found) begin
                        phase_d = GREEN;
                        timer_d = LD_GREEN;
                        idx_d   = win_idx;
                    end
                end
                GREEN: begin
                    if (preempt) begin
                        phase_d = YELLOW;
                        timer_d = LD_YELLOW;
                    end else if (freeze) begin
                        timer_d = timer_q;
                    end else if (timer_q == '0) begin
                        phase_d = bus.cong[idx_q] ? EXT_GREEN : YELLOW;
                        timer_d = bus.cong[idx_q] ? LD_EXT : LD_YELLOW;
                    end else begin
                        timer_d = timer_q - CNT_W'(1);
                    end
                end
                EXT_GREEN: begin
                    if (preempt || (!freeze && timer_q == '0)) begin
                        phase_d = YELLOW;
                        timer_d = LD_YELLOW;
                    end else if (!freeze) begin
                        timer_d = timer_q - CNT_W'(1);
                    end
                end
                YELLOW: begin
                    if (timer_q == '0) begin
                        phase_d = ALL_RED;
                        timer_d = LD_ALLRED;
                    end else begin
                        timer_d = timer_q - CNT_W'(1);
                    end
                end
            endcase
        end

        // Lamp outputs are precomputed from the next state so they leave flops directly.
        green_d  = ((phase_d == GREEN) || (phase_d == EXT_GREEN)) ? (N_APPR'(1) << idx_d) : '0;
        yellow_d = (phase_d == YELLOW) ? (N_APPR'(1) << idx_d) : '0;
        done_d   = (phase_d == YELLOW) && (timer_d == '0);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q  <= ALL_RED;
            timer_q  <= LD_ALLRED;
            idx_q    <= LAST_IDX;
            green_q  <= '0;
            yellow_q <= '0;
            done_q   <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            timer_q  <= timer_d;
            idx_q    <= idx_d;
            green_q  <= green_d;
            yellow_q <= yellow_d;
            done_q   <= done_d;
        end
    end

    assign bus.state      = phase_q;
    assign bus.active_idx = idx_q;
    assign bus.green      = green_q;
    assign bus.yellow     = yellow_q;
    assign bus.phase_done = done_q;

endmodule

// File: tb/tb_adaptive_phase_controller.sv
// Scoreboard bench: a phase-level reference model predicts every cycle's lamp state,
// and an independent monitor compares the controller's registered outputs against it.
module tb_adaptive_phase_controller;
    localparam int N  = 4;
    localparam int TG = 4;
    localparam int TE = 3;
    localparam int TY = 2;
    localparam int TA = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    adaptive_phase_controller_if #(.N_APPR(N)) bus ();

    adaptive_phase_controller #(
        .N_APPR(N), .T_GREEN(TG), .T_EXT(TE), .T_YELLOW(TY), .T_ALLRED(TA), .CNT_W(8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

`ifdef EMERG_PREEMPT_EN
    initial begin
        bus.emerg_req = 1'b0;
        bus.emerg_idx = '0;
    end
`endif

    typedef struct packed {
        logic [1:0] st;
        logic [1:0] idx;
        logic [3:0] g;
        logic [3:0] y;
        logic       pd;
    } obs_t;

    obs_t exp_q[$];
    int   served_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model: current phase (0 AR, 1 G, 2 EXT, 3 Y), cycles already spent in it, served approach.
    int m_phase;
    int m_elapsed;
    int m_idx;

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    function automatic int arbitrate(logic [3:0] v, logic [3:0] c, int last);
        int order[$];
        for (int k = 1; k <= N; k++) order.push_back((last + k) % N);
        foreach (order[i]) if (c[order[i]]) return order[i];
        foreach (order[i]) if (v[order[i]]) return order[i];
        return -1;
    endfunction

    task automatic model_reset();
        m_phase   = 0;
        m_elapsed = 0;
        m_idx     = N - 1;
    endtask

    task automatic model_step(logic [3:0] v, logic [3:0] c);
        obs_t e;
        int   w;
        case (m_phase)
            0: begin
                if (m_elapsed >= TA - 1) begin
                    w = arbitrate(v, c, m_idx);
                    if (w >= 0) begin
                        m_phase = 1; m_elapsed = 0; m_idx = w;
                    end
                end else m_elapsed++;
            end
            1: begin
                if (m_elapsed == TG - 1) begin
                    m_phase = c[m_idx] ? 2 : 3; m_elapsed = 0;
                end else m_elapsed++;
            end
            2: begin
                if (m_elapsed == TE - 1) begin
                    m_phase = 3; m_elapsed = 0;
                end else m_elapsed++;
            end
            default: begin
                if (m_elapsed == TY - 1) begin
                    m_phase = 0; m_elapsed = 0;
                end else m_elapsed++;
            end
        endcase
        e.st  = 2'(m_phase);
        e.idx = 2'(m_idx);
        e.g   = (m_phase == 1 || m_phase == 2) ? 4'(1 << m_idx) : 4'b0;
        e.y   = (m_phase == 3) ? 4'(1 << m_idx) : 4'b0;
        e.pd  = (m_phase == 3) && (m_elapsed == TY - 1);
        exp_q.push_back(e);
    endtask

    task automatic run(logic [3:0] v, logic [3:0] c, int n);
        repeat (n) begin
            @(negedge clk);
            bus.veh  = v;
            bus.cong = c;
            model_step(v, c);
        end
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_state"}, 32'(bus.state), 32'd0);
        check({tag, "_idx"},   32'(bus.active_idx), 32'(N - 1));
        check({tag, "_green"}, 32'(bus.green), 32'd0);
        check({tag, "_yellow"}, 32'(bus.yellow), 32'd0);
        check({tag, "_done"},  32'(bus.phase_done), 32'd0);
    endtask

    // Monitor: every cycle the controller presents a new registered phase; compare it to the model.
    initial begin
        obs_t       e, a;
        logic [1:0] prev;
        prev = 2'd0;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {bus.state, bus.active_idx, bus.green, bus.yellow, bus.phase_done};
                check("cycle_obs", 32'(a), 32'(e));
            end
            if (bus.state == 2'd1 && prev != 2'd1) served_q.push_back(int'(bus.active_idx));
            prev = bus.state;
        end
    end

    initial begin
        logic [3:0] rv, rc;
        int         exp_order[5];
        exp_order = '{0, 1, 2, 3, 0};
        bus.veh  = '0;
        bus.cong = '0;
        model_reset();

        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Single requester, then idle, then a new request served on the next cycle.
        run(4'b0100, 4'b0000, 7);
        run(4'b0000, 4'b0000, 8);
        run(4'b0001, 4'b0000, 8);
        // Serve approach 1, then congestion on 1 and 3 with all present.
        run(4'b0010, 4'b0000, 8);
        run(4'b1111, 4'b1010, 14);
        run(4'b0000, 4'b0000, 6);

        // Randomized traffic with occasional congestion and idle periods.
        repeat (120) begin
            rv = ($urandom_range(0, 3) == 0) ? 4'b0 : 4'($urandom);
            rc = 4'($urandom & $urandom);
            run(rv, rc, $urandom_range(1, 6));
        end

        // Drive approach 2 into its extended green, then pulse reset mid-phase.
        run(4'b0000, 4'b0000, 12);
        for (int i = 0; i < 40 && !(m_phase == 2 && m_idx == 2); i++) run(4'b0100, 4'b0100, 1);
        @(posedge clk);
        #2;
        check("pre_rst_state", 32'(bus.state), 32'd2);
        check("pre_rst_green", 32'(bus.green), 32'b0100);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        exp_q.delete();
        model_reset();
        bus.veh  = '0;
        bus.cong = '0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // All approaches present from reset: strict round-robin service order.
        served_q.delete();
        run(4'b1111, 4'b0000, 40);
        @(posedge clk);
        #2;
        for (int i = 0; i < 5; i++)
            check($sformatf("order%0d", i),
                  (i < served_q.size()) ? 32'(served_q[i]) : 32'hFFFF_FFFF, 32'(exp_order[i]));

        repeat (120) begin
            rv = ($urandom_range(0, 4) == 0) ? 4'b0 : 4'($urandom);
            rc = 4'($urandom & $urandom & $urandom);
            run(rv, rc, $urandom_range(1, 8));
        end

        @(posedge clk);
        #2;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/adaptive_phase_controller.md
ADAPTIVE_PHASE_CONTROLLER -- requirements
Module: adaptive_phase_controller

Interface
REQ-001 Parameter N_APPR, default 4, number of approaches (legal range 2..8).
REQ-002 Parameter T_GREEN, default 8, primary green duration in cycles (>=1).
REQ-003 Parameter T_EXT, default 6, extended green duration in cycles (>=1).
REQ-004 Parameter T_YELLOW, default 3, yellow duration in cycles (>=1).
REQ-005 Parameter T_ALLRED, default 2, all-red clearance duration in cycles (>=1).
REQ-006 Parameter CNT_W, default 8, phase timer width; every T_* SHALL be <= 2^CNT_W-1.
REQ-007 clk  input  1  system clock, all state updates on rising edge.
REQ-008 rst_n  input  1  reset, asynchronous, active-low.
REQ-009 veh  input  N_APPR  per-approach vehicle presence, bit i = approach i.
REQ-010 cong  input  N_APPR  per-approach congestion flag.
REQ-011 state  output  2  phase: 0 ALL_RED, 1 GREEN, 2 EXT_GREEN, 3 YELLOW.
REQ-012 active_idx  output  clog2(N_APPR)  approach currently served (or last served in ALL_RED).
REQ-013 green  output  N_APPR  one-hot green, zero outside GREEN/EXT_GREEN.
REQ-014 yellow  output  N_APPR  one-hot yellow, zero outside YELLOW.
REQ-015 phase_done  output  1  one-cycle pulse on the last YELLOW cycle.

Function
REQ-016 All outputs SHALL be Moore: driven from registers only, no combinational input-to-output path.
REQ-017 A down-counting timer SHALL load duration-1 on state entry; a state with duration D SHALL occupy exactly D cycles; exit occurs on the cycle timer==0.
REQ-018 ALL_RED: after clearance expires, arbitration SHALL run every cycle until a winner exists; with no veh/cong bits set, remain ALL_RED with timer held at 0.
REQ-019 Arbitration: round-robin search starting at (active_idx+1) mod N_APPR, wrap-around; first approach with cong set wins; else first with veh set wins.
REQ-020 Winner SHALL enter GREEN next cycle; active_idx updates to the winner in the same cycle.
REQ-021 GREEN expiry: cong[active_idx]==1 -> EXT_GREEN; else -> YELLOW; EXT_GREEN granted at most once per service.
REQ-022 EXT_GREEN expiry -> YELLOW; YELLOW expiry -> ALL_RED with phase_done=1 on the final YELLOW cycle.
REQ-023 Deassertion of veh/cong during GREEN/EXT_GREEN SHALL NOT shorten the phase.
REQ-024 Every green SHALL be preceded by YELLOW then ALL_RED of the previous approach; no direct green-to-green transition.
REQ-025 Illegal state encodings are impossible with 2 bits; invalid active_idx (>=N_APPR) SHALL force ALL_RED and active_idx=N_APPR-1.

Reset
REQ-026 On rst_n low: state=ALL_RED, active_idx=N_APPR-1 (first search starts at 0), timer=T_ALLRED-1, green=0, yellow=0, phase_done=0.
REQ-027 Reset asserted mid-phase SHALL clear green/yellow immediately (asynchronously); after release a full T_ALLRED clearance precedes any green.

Configuration
REQ-028 Macro EMERG_PREEMPT_EN: when defined, add inputs emerg_req (1) and emerg_idx (clog2(N_APPR)).
REQ-029 With macro: emerg_req during GREEN/EXT_GREEN of another approach SHALL force YELLOW next cycle; in ALL_RED arbitration emerg_idx wins over all cong/veh; during GREEN/EXT_GREEN of emerg_idx the timer SHALL freeze while emerg_req=1.
REQ-030 Without macro: ports absent; behaviour exactly as REQ-016..REQ-027.

Verification (N_APPR=4, T_GREEN=4, T_EXT=3, T_YELLOW=2, T_ALLRED=1)
REQ-031 Release reset, veh=4'b0100 -> ALL_RED 1 cycle, GREEN active_idx=2 for 4 cycles, YELLOW 2 cycles with phase_done on 2nd, ALL_RED.
REQ-032 veh=4'b1111 held constant -> service order 0,1,2,3,0, each green exactly 4 cycles.
REQ-033 Served approach 1, cong=4'b1010, veh=4'b1111 -> next winner 3; cong[3] held -> GREEN 4 + EXT_GREEN 3 cycles, then YELLOW.
REQ-034 veh=0 after yellow -> stays ALL_RED indefinitely; veh=4'b0001 asserted -> GREEN idx 0 on the next cycle.
REQ-035 rst_n pulsed low during EXT_GREEN idx 2 -> green=0 same cycle, active_idx=3, state=ALL_RED.
REQ-036 EMERG_PREEMPT_EN, GREEN idx 0 cycle 2, emerg_req=1 emerg_idx=3 -> YELLOW next cycle, ALL_RED, GREEN idx 3 held while emerg_req=1.
